// File: rtl/conf_int_pkg.sv
// Shared definitions for the configurable integer MAC and its inverse (divider) stage.
// Holds the FSM state encoding and the default operand/datapath widths.
package conf_int_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int OP_BITWIDTH_DEF        = 16;
   localparam int DATA_PATH_BITWIDTH_DEF = 16;

endpackage

// File: rtl/conf_int_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder,
// subtract the divisor when it fits and report the resulting quotient bit.
module conf_int_div_step #(
   parameter int OP_BITWIDTH = 16
) (
   input  logic [OP_BITWIDTH:0]   i_rem,
   input  logic                   i_dividend_bit,
   input  logic [OP_BITWIDTH-1:0] i_divisor,
   output logic [OP_BITWIDTH:0]   o_rem,
   output logic                   o_q_bit
);

   logic [OP_BITWIDTH+1:0] w_partial;
   logic [OP_BITWIDTH:0]   w_sub;

   assign w_partial = {i_rem, i_dividend_bit};
   // The incoming remainder is always below the divisor, so the difference fits in OP+1 bits.
   assign w_sub     = w_partial[OP_BITWIDTH:0] - {1'b0, i_divisor};
   assign o_q_bit   = (w_partial >= {2'b00, i_divisor});
   assign o_rem     = o_q_bit ? w_sub : w_partial[OP_BITWIDTH:0];

endmodule

// File: rtl/conf_int_mac_inverse_seq.sv
// Sequential inverse of the integer MAC: recovers a = (d - c_in) / b and r = (d - c_in) % b
// with a bit-serial restoring divider behind valid/ready handshakes.
module conf_int_mac_inverse_seq
   import conf_int_pkg::*;
#(
   parameter int OP_BITWIDTH        = OP_BITWIDTH_DEF,
   parameter int DATA_PATH_BITWIDTH = DATA_PATH_BITWIDTH_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_PATH_BITWIDTH-1:0] d,
   input  logic [DATA_PATH_BITWIDTH-1:0] b,
   input  logic [DATA_PATH_BITWIDTH-1:0] c_in,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_PATH_BITWIDTH-1:0] a,
   output logic [DATA_PATH_BITWIDTH-1:0] r,
   output logic                          div_by_zero
);

   localparam int OP  = OP_BITWIDTH;
   localparam int DPW = DATA_PATH_BITWIDTH;
   localparam int CW  = (OP > 1) ? $clog2(OP) : 1;

   state_t           r_state;
   state_t           w_next;
   logic [OP-1:0]    r_dvd;
   logic [OP-1:0]    r_dsr;
   logic [OP:0]      r_rem;
   logic [OP-1:0]    r_quo;
   logic [CW-1:0]    r_cnt;
   logic [DPW-1:0]   r_a;
   logic [DPW-1:0]   r_r;
   logic             r_dbz;

   logic [DPW-1:0]   w_diff;
   logic [OP-1:0]    w_dividend;
   logic [OP-1:0]    w_divisor;
   logic             w_accept;
   logic [OP:0]      w_rem_next;
   logic             w_q_bit;
   logic [OP-1:0]    w_quo_next;

   assign w_diff     = d - c_in;
   assign w_dividend = w_diff[OP-1:0];
   assign w_divisor  = b[OP-1:0];
   assign w_accept   = in_valid & in_ready;
   assign w_quo_next = OP'({r_quo, w_q_bit});

   conf_int_div_step #(.OP_BITWIDTH(OP)) u_step (
      .i_rem          (r_rem),
      .i_dividend_bit (r_dvd[OP-1]),
      .i_divisor      (r_dsr),
      .o_rem          (w_rem_next),
      .o_q_bit        (w_q_bit)
   );

   // Next-state and handshake outputs; a zero divisor skips the iterations entirely.
   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_next = (w_divisor == '0) ? S_DONE : S_ITER;
         end
         S_ITER: begin
            if (r_cnt == '0) w_next = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Result registers only change at accept (divide-by-zero) or on the last iteration,
   // so they stay frozen while the consumer applies backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_dvd   <= '0;
         r_dsr   <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
         r_cnt   <= '0;
         r_a     <= '0;
         r_r     <= '0;
         r_dbz   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_dvd <= w_dividend;
            r_dsr <= w_divisor;
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= CW'(OP - 1);
            if (w_divisor == '0) begin
               r_a   <= DPW'({OP{1'b1}});
               r_r   <= DPW'(w_dividend);
               r_dbz <= 1'b1;
            end
         end else if (r_state == S_ITER) begin
            r_dvd <= r_dvd << 1;
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            if (r_cnt == '0) begin
               r_a   <= DPW'(w_quo_next);
               r_r   <= DPW'(w_rem_next);
               r_dbz <= 1'b0;
            end else begin
               r_cnt <= r_cnt - 1'b1;
            end
         end
      end
   end

   assign a           = r_a;
   assign r           = r_r;
   assign div_by_zero = r_dbz;

endmodule
